// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and width helpers for the button debouncer
package debounce_pkg;
  localparam int DEF_N_CH = 5;
  localparam int DEF_CLK_HZ = 100_000_000;
  localparam int DEF_TICK_HZ = 1000;
  localparam int DEF_STABLE_TICKS = 10;
  localparam int DEF_REPEAT_DELAY = 500;
  localparam int DEF_REPEAT_RATE = 100;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// debounce_chan: one button channel with synchroniser, stability filter, edge pulses and auto-repeat
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_EN = 0,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int CW = clog2(STABLE_TICKS + 1);
  localparam int RW = clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);
  localparam logic [RW-1:0] RDLY = RW'(REPEAT_DELAY);
  localparam logic [RW-1:0] RRATE = RW'(REPEAT_RATE);
  logic s1, s2, first, accept;
  logic [CW-1:0] cnt;
  logic [RW-1:0] rcnt, rnext;
  always_comb begin
    accept = tick && (s2 != level) && (cnt == CMAX);
    rnext = rcnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      rcnt <= '0;
      first <= 1'b1;
      level <= 1'b0;
      press <= 1'b0;
      rel <= 1'b0;
      rpt <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      press <= accept && s2;
      rel <= accept && !s2;
      rpt <= 1'b0;
      if (tick) cnt <= (s2 == level || accept) ? '0 : cnt + 1'b1;
      if (accept) level <= s2;
      // the press cycle and any released cycle restart the repeat phase
      if (accept || !level) begin
        rcnt <= '0;
        first <= 1'b1;
      end else if (tick) begin
        if (rnext == (first ? RDLY : RRATE)) begin
          rpt <= REPEAT_EN != 0;
          rcnt <= '0;
          first <= 1'b0;
        end else begin
          rcnt <= rnext;
        end
      end
    end
  end
endmodule

// File: rtl/debounce_bank.sv
// debounce_bank: shared tick prescaler feeding N_CH independent debounce channels
module debounce_bank
  import debounce_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int REPEAT_EN = 0,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_RATE = DEF_REPEAT_RATE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt,
  output logic            tick
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  logic [PW-1:0] pc;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= '0;
      tick <= 1'b0;
    end else begin
      pc <= (pc == PMAX) ? '0 : pc + 1'b1;
      tick <= pc == PMAX;
    end
  end
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .REPEAT_EN(REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_RATE(REPEAT_RATE)
    ) u_chan (
      .clk(clk),
      .rst_n(rst_n),
      .tick(tick),
      .btn(btn_in[g]),
      .level(level[g]),
      .press(press[g]),
      .rel(rel[g]),
      .rpt(rpt[g])
    );
  end
endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank: random and directed stimulus checked every cycle against a sample-history model
module tb_debounce_bank;
  localparam int N = 2, DIV = 10, ST = 3, DLY = 4, RATE = 2;
  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] btn_in, level, press, rel, rpt;
  logic tick;
  int vectors = 0, errs = 0, cyc = 0;
  int n, ns[N], ht[N], hold[N];
  logic [N-1:0] q0, q1, e_level, e_press, e_rel, e_rpt;
  logic [ST-1:0] win[N];
  logic e_tick;

  debounce_bank #(
    .N_CH(N), .CLK_HZ(100), .TICK_HZ(10), .STABLE_TICKS(ST),
    .REPEAT_EN(1), .REPEAT_DELAY(DLY), .REPEAT_RATE(RATE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_in(btn_in), .level(level),
    .press(press), .rel(rel), .rpt(rpt), .tick(tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [N-1:0] a, input logic [N-1:0] e);
    vectors++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, a, e);
    end
  endtask

  task automatic lit(input string nm, input int a, input int e);
    vectors++;
    if (a != e) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  // model: a change is accepted once the last ST tick samples all differ from the level
  task automatic step();
    logic tk;
    @(posedge clk);
    if (!rst_n) begin
      n = 0; q0 = '0; q1 = '0;
      e_level = '0; e_press = '0; e_rel = '0; e_rpt = '0; e_tick = 1'b0;
      for (int c = 0; c < N; c++) begin win[c] = '0; ns[c] = 0; ht[c] = 0; end
    end else begin
      tk = n > 0 && n % DIV == 0;
      e_press = '0; e_rel = '0; e_rpt = '0;
      for (int c = 0; c < N; c++) begin
        if (tk) begin
          win[c] = {win[c][ST-2:0], q1[c]};
          ns[c]++;
          if (ns[c] >= ST && win[c] == {ST{~e_level[c]}}) begin
            e_level[c] = ~e_level[c];
            if (e_level[c]) e_press[c] = 1'b1; else e_rel[c] = 1'b1;
            ns[c] = 0;
            ht[c] = 0;
          end else if (e_level[c]) begin
            ht[c]++;
            if (ht[c] == DLY || (ht[c] > DLY && (ht[c] - DLY) % RATE == 0)) e_rpt[c] = 1'b1;
          end
        end
        if (!e_level[c]) ht[c] = 0;
      end
      q1 = q0; q0 = btn_in; n++;
      e_tick = n % DIV == 0;
    end
    #1;
    cyc++;
    chk("level", level, e_level);
    chk("press", press, e_press);
    chk("release", rel, e_rel);
    chk("rpt", rpt, e_rpt);
    chk("tick", {1'b0, tick}, {1'b0, e_tick});
  endtask

  initial begin
    int k, chg, found, t, nr;
    int rt[3];
    rst_n = 1'b0; btn_in = 2'b11;
    repeat (5) step();
    lit("reset_outputs", int'({level, press, rel, rpt, tick}), 0);
    rst_n = 1'b1; btn_in = 2'b00;
    k = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (tick && k == 0) k = i;
    end
    lit("first_tick_clk", k, 10);

    btn_in[0] = 1'b1;
    found = 0; k = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin step(); k = i + 1; found = int'(level[0]); end
    lit("press_latency_in_range", int'(k >= 22 && k <= 32), 1);
    lit("press_with_level", int'(press[0]), 1);
    lit("ch1_untouched", int'(level[1] | press[1]), 0);
    step();
    lit("press_width", int'(press[0]), 0);
    repeat (10) step();

    chg = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 15 == 0) btn_in[0] = ~btn_in[0];
      step();
      if (!level[0] || press[0] || rel[0]) chg++;
    end
    lit("bounce_changes", chg, 0);
    btn_in[0] = 1'b1;
    repeat (40) step();

    btn_in[1] = 1'b1;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin step(); found = int'(press[1]); end
    lit("ch1_press_seen", found, 1);
    t = 0; nr = 0;
    for (int i = 0; i < 90; i++) begin
      step(); t++;
      if (rpt[1] && nr < 3) begin rt[nr] = t; nr++; end
    end
    lit("rpt_count", nr, 3);
    lit("rpt_first", rt[0], 40);
    lit("rpt_second", rt[1], 60);
    lit("rpt_third", rt[2], 80);
    btn_in[1] = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin step(); found = int'(rel[1]); end
    lit("ch1_release_seen", found, 1);
    nr = 0;
    for (int i = 0; i < 100; i++) begin step(); nr += int'(rpt[1]); end
    lit("rpt_after_release", nr, 0);

    btn_in = 2'b00;
    repeat (50) step();
    btn_in = 2'b11;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin step(); found = int'(press != 0); end
    lit("simultaneous_press", int'(press), 3);

    btn_in = 2'b00;
    repeat (50) step();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin step(); found = int'(tick); end
    lit("tick_found", found, 1);
    btn_in[0] = 1'b1;
    repeat (24) step();
    lit("no_level_before_reset", int'(level[0]), 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    found = 0; k = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin step(); k = i + 1; found = int'(level[0]); end
    lit("level_after_mid_reset", k, 31);

    hold[0] = 0; hold[1] = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < N; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = ~btn_in[c];
          hold[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 400)) : int'($urandom_range(1, 25));
        end
        hold[c]--;
      end
      rst_n = ($urandom_range(0, 1499) == 0) ? 1'b0 : 1'b1;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel push-button debouncer for the Basys3 user buttons, feeding the UART transmit trigger and other front-panel controls. Each of N_CH asynchronous button inputs is synchronised into the single system clock domain and sampled on a shared clock-enable tick. An input change is accepted only after it has been stable for a programmable number of ticks. Each channel provides a clean level, single-cycle press/release pulses and an optional auto-repeat pulse train; no derived clocks are used.

## Interface
- N_CH, 5, number of button channels (≥1)
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, sample-tick rate; DIV = CLK_HZ/TICK_HZ (integer division), DIV ≥ 2
- STABLE_TICKS, 10, consecutive differing samples required to accept a change (≥1)
- REPEAT_EN, 0, 1 enables auto-repeat
- REPEAT_DELAY, 500, ticks held before the first repeat pulse (≥1)
- REPEAT_RATE, 100, ticks between later repeat pulses (≥1)

- clk  in  1  system clock; the only clock
- rst_n  in  1  synchronous, active-low reset
- btn_in  in  N_CH  raw asynchronous buttons, active-high
- level  out  N_CH  debounced button state
- press  out  N_CH  one-cycle pulse on an accepted 0→1 change
- release  out  N_CH  one-cycle pulse on an accepted 1→0 change
- rpt  out  N_CH  one-cycle auto-repeat pulse; constant 0 when REPEAT_EN=0
- tick  out  1  shared sample enable, high for one clk per DIV cycles

## Operation
- Prescaler: the counter runs 0..DIV-1 and wraps to 0. tick is registered and is high in the cycle after the counter equals DIV-1.
- Per channel, btn_in passes through a 2-flop synchroniser (s1, s2) clocked every cycle.
- Stability counter cnt has width clog2(STABLE_TICKS+1). It is updated only in cycles where tick=1:
  - s2 == level: cnt←0.
  - s2 != level and cnt == STABLE_TICKS-1: level←s2, cnt←0, and press or release is asserted for that one cycle.
  - otherwise: cnt←cnt+1.
- A bounce back to the accepted level on any tick clears cnt. Glitches between ticks are not sampled.
- Auto-repeat (REPEAT_EN=1): rcnt has width clog2(max(REPEAT_DELAY,REPEAT_RATE)+1). Phase flag first=1 after a press.
  - On a tick with level=1, rcnt increments.
  - When rcnt reaches REPEAT_DELAY (first=1) or REPEAT_RATE (first=0): rpt←1 for one cycle, rcnt←0, first←0.
  - When level=0 or in the press cycle: rcnt←0, first←1. No rpt occurs in the same cycle as press or release.
- Channels are fully independent. Simultaneous events on several channels all pulse in the same cycle.

## Timing
- Reset, while rst_n=0 at a clk edge: prescaler, s1, s2, cnt, rcnt cleared; first←1; level, press, release, rpt, tick all 0.
- Reset mid-bounce or mid-hold discards all progress. After release of reset, a held button is re-accepted as a fresh press after full stabilisation.
- Latency from a btn_in step (clean) to a level change: 2 clk (synchroniser) plus wait to the next tick, plus (STABLE_TICKS-1)·DIV clk. Bounds: [2+(STABLE_TICKS-1)·DIV, 2+STABLE_TICKS·DIV] clk.
- press, release and level change on the same clk edge. The pulses are exactly 1 clk wide.
- The first rpt comes REPEAT_DELAY ticks after press; subsequent rpt pulses follow every REPEAT_RATE ticks while held.
- All outputs are registered; no combinational path from btn_in.

## Structure
- Package debounce_pkg: clog2-style width function, default constants (CLK_HZ, TICK_HZ, STABLE_TICKS, repeat defaults).
- Sub-module debounce_chan: one channel (synchroniser, stability counter, edge pulses, repeat logic), taking tick as input and generated N_CH times.
- The prescaler stays in debounce_bank and is shared by all channels.

## Test plan
All scenarios use CLK_HZ=100, TICK_HZ=10 (DIV=10), STABLE_TICKS=3, REPEAT_EN=1, REPEAT_DELAY=4, REPEAT_RATE=2, N_CH=2.

- Reset: hold rst_n=0 for 5 clk with btn_in=2'b11 → all outputs 0; after release, tick first high 10 clk later.
- Clean press on ch0: btn_in[0] 0→1 held → level[0]=1 within 22–32 clk, press[0] exactly 1 clk wide on the same edge, ch1 untouched.
- Bounce rejection on ch0: toggle btn_in[0] every 15 clk for 100 clk → no level, press or release change.
- Auto-repeat: hold ch1 → rpt[1] at 4 ticks (40 clk) after press[1], then every 20 clk. Release → release[1] after stabilisation, no further rpt.
- Simultaneous: press both channels on the same clk → press=2'b11 in one cycle.
- Reset mid-hold: after 2 accepted ticks, pulse rst_n low for 1 clk → cnt cleared; level rises only 3 full ticks later.
